// File: rtl/hazard_pipe_regs.sv
// hazard_pipe_regs: E/M/W pipeline registers for the hazard-relevant control
// and register-number fields. Builds the packed buses the hazard unit reads
// back, and keeps saturating stall/flush event counters for performance debug.
module hazard_pipe_regs #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REGW-1:0]     rsD,
    input  logic [REGW-1:0]     rtD,
    input  logic [REGW-1:0]     rdD,
    input  logic                RegWriteD,
    input  logic                MemtoRegD,
    input  logic                RegDstD,
    input  logic                StallD,
    input  logic                FlushE,
    output logic [4:0]          hazard_single_bus,
    output logic [7*REGW-1:0]   hazard_mult_bus,
    output logic [REGW-1:0]     rsE,
    output logic [REGW-1:0]     rtE,
    output logic [REGW-1:0]     WriteRegE,
    output logic [REGW-1:0]     WriteRegM,
    output logic [REGW-1:0]     WriteRegW,
    output logic [CNTW-1:0]     stall_cnt,
    output logic [CNTW-1:0]     flush_cnt
);

    // E-stage state
    logic [REGW-1:0] rsE_r;
    logic [REGW-1:0] rtE_r;
    logic [REGW-1:0] rdE_r;
    logic            regWriteE_r;
    logic            memtoRegE_r;
    logic            regDstE_r;

    // M-stage state
    logic [REGW-1:0] writeRegM_r;
    logic            regWriteM_r;
    logic            memtoRegM_r;

    // W-stage state
    logic [REGW-1:0] writeRegW_r;
    logic            regWriteW_r;

    // Event counters
    logic [CNTW-1:0] stallCnt_r;
    logic [CNTW-1:0] flushCnt_r;

    // Derived E-stage destination
    logic [REGW-1:0] writeRegE_s;

    // Increment-with-hold: counts stick at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] value,
                                               input logic            enable);
        logic [CNTW-1:0] result;
        if (enable && (value != {CNTW{1'b1}})) begin
            result = value + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    // E stage: capture decode fields, or load a bubble on FlushE. StallD does
    // not hold this stage; the hazard unit pairs it with FlushE.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            rsE_r       <= {REGW{1'b0}};
            rtE_r       <= {REGW{1'b0}};
            rdE_r       <= {REGW{1'b0}};
            regWriteE_r <= 1'b0;
            memtoRegE_r <= 1'b0;
            regDstE_r   <= 1'b0;
        end else begin
            rsE_r       <= rsD;
            rtE_r       <= rtD;
            rdE_r       <= rdD;
            regWriteE_r <= RegWriteD;
            memtoRegE_r <= MemtoRegD;
            regDstE_r   <= RegDstD;
        end
    end

    // E-stage destination select: rd for R-type, rt otherwise.
    always_comb begin
        writeRegE_s = {REGW{1'b0}};
        if (regDstE_r) begin
            writeRegE_s = rdE_r;
        end else begin
            writeRegE_s = rtE_r;
        end
    end

    // M stage: unconditional advance from E.
    always_ff @(posedge clk) begin
        if (reset) begin
            writeRegM_r <= {REGW{1'b0}};
            regWriteM_r <= 1'b0;
            memtoRegM_r <= 1'b0;
        end else begin
            writeRegM_r <= writeRegE_s;
            regWriteM_r <= regWriteE_r;
            memtoRegM_r <= memtoRegE_r;
        end
    end

    // W stage: unconditional advance from M.
    always_ff @(posedge clk) begin
        if (reset) begin
            writeRegW_r <= {REGW{1'b0}};
            regWriteW_r <= 1'b0;
        end else begin
            writeRegW_r <= writeRegM_r;
            regWriteW_r <= regWriteM_r;
        end
    end

    // Saturating stall/flush event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_r <= {CNTW{1'b0}};
            flushCnt_r <= {CNTW{1'b0}};
        end else begin
            stallCnt_r <= satInc(stallCnt_r, StallD);
            flushCnt_r <= satInc(flushCnt_r, FlushE);
        end
    end

    // Output mapping and bus packing; rsD/rtD bus fields pass straight through.
    always_comb begin
        rsE       = rsE_r;
        rtE       = rtE_r;
        WriteRegE = writeRegE_s;
        WriteRegM = writeRegM_r;
        WriteRegW = writeRegW_r;
        stall_cnt = stallCnt_r;
        flush_cnt = flushCnt_r;
        hazard_single_bus = {memtoRegE_r, regWriteE_r, memtoRegM_r,
                             regWriteM_r, regWriteW_r};
        hazard_mult_bus   = {rsD, rtD, rsE_r, rtE_r, writeRegE_s,
                             writeRegM_r, writeRegW_r};
    end

endmodule
